// File: rtl/clk_wiz_example_design.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module   : clk_wiz_example_design
// Brief    : Lock-sequencing model of a clocking wizard with glitch-free gated
//            1:1 copy of dac_clk on CLK_OUT[1].
// Revision : 1.0 - initial release
// ============================================================================
module clk_wiz_example_design #(
  parameter int PER_DAC_CLK  = 3125,
  parameter int PER_PCIE_CLK = 3125,
  parameter int LOCK_CYCLES  = 64
) (
  input  logic       dac_clk,
  input  logic       reset,
  input  logic       power_down,
  input  logic       pcie_clk,
  output logic [1:1] CLK_OUT,
  output logic       locked,
  output logic       input_clk_stopped
);

  localparam logic [15:0] c_lock_last = 16'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_LOCKING = 2'd1,
    S_LOCKED  = 2'd2,
    S_PWRDN   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lock_cnt;
  logic [15:0] w_lock_cnt_nxt;
  logic [15:0] w_lock_cnt_inc;
  logic        r_locked;
  logic        w_locked_nxt;
  logic        r_stopped;
  logic        w_stopped_nxt;
  logic        r_gate_q;
  logic        w_unused;

  // pcie_clk and the period parameters exist only for pin/parameter compatibility
  assign w_unused = pcie_clk ^ (PER_DAC_CLK > 0) ^ (PER_PCIE_CLK > 0);

  assign w_lock_cnt_inc = r_lock_cnt + 16'd1;

  always_ff @(posedge dac_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RESET;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_stopped  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_locked   <= w_locked_nxt;
      r_stopped  <= w_stopped_nxt;
    end
  end

  // power_down is tested before lock completion so the collision edge never locks
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      S_RESET, S_PWRDN: begin
        w_lock_cnt_nxt = '0;
        if (power_down)
          w_state_nxt = S_PWRDN;
        else if (c_lock_last == 16'd0)
          w_state_nxt = S_LOCKED;
        else
          w_state_nxt = S_LOCKING;
      end
      S_LOCKING: begin
        if (power_down) begin
          w_state_nxt    = S_PWRDN;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = w_lock_cnt_inc;
          if (w_lock_cnt_inc == c_lock_last)
            w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (power_down) begin
          w_state_nxt    = S_PWRDN;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = S_RESET;
        w_lock_cnt_nxt = '0;
      end
    endcase
    w_locked_nxt  = (w_state_nxt == S_LOCKED);
    w_stopped_nxt = (w_state_nxt == S_PWRDN) || (w_state_nxt == S_RESET);
  end

  // Enable is resampled only while dac_clk is low, so the AND below cannot runt
  always_ff @(negedge dac_clk or negedge reset) begin
    if (!reset)
      r_gate_q <= 1'b0;
    else
      r_gate_q <= r_locked;
  end

  assign CLK_OUT[1]        = dac_clk & r_gate_q;
  assign locked            = r_locked;
  assign input_clk_stopped = r_stopped;

endmodule
`default_nettype wire

// File: tb/tb_clk_wiz_example_design.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clk_wiz_example_design
// Brief    : Scoreboard bench for clk_wiz_example_design (LOCK_CYCLES = 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_wiz_example_design;

  logic       dac_clk    = 1'b0;
  logic       reset      = 1'b1;
  logic       power_down = 1'b0;
  logic       pcie_clk   = 1'b0;
  logic [1:1] clk_out;
  logic       locked;
  logic       input_clk_stopped;

  int         pcie_mode = 0;
  int         checks    = 0;
  int         errors    = 0;
  int         clk_edges = 0;
  time        rise_t[$];

  logic [2:0] exp_q[$];
  string      name_q[$];
  int         seq_q[$];

  clk_wiz_example_design #(
    .PER_DAC_CLK  (3125),
    .PER_PCIE_CLK (3125),
    .LOCK_CYCLES  (64)
  ) dut (
    .dac_clk           (dac_clk),
    .reset             (reset),
    .power_down        (power_down),
    .pcie_clk          (pcie_clk),
    .CLK_OUT           (clk_out),
    .locked            (locked),
    .input_clk_stopped (input_clk_stopped)
  );

  always begin
    #1562 dac_clk = 1'b1;
    #1563 dac_clk = 1'b0;
  end

  always begin
    #1562;
    if (pcie_mode == 0) pcie_clk = ~pcie_clk; else pcie_clk = (pcie_mode == 2);
    #1563;
    if (pcie_mode == 0) pcie_clk = ~pcie_clk; else pcie_clk = (pcie_mode == 2);
  end

  always @(posedge clk_out[1]) begin
    clk_edges++;
    rise_t.push_back($time);
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Monitor: outputs are sampled 1 ps into the high phase following each edge.
  initial begin : monitor
    logic [2:0] e;
    logic [2:0] act;
    string      n;
    int         s;
    forever begin
      @(posedge dac_clk);
      #1;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        s   = seq_q.pop_front();
        act = {locked, input_clk_stopped, clk_out[1]};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s edge %0d: locked/stopped/clk_out got %b required %b", n, s, act, e);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic pd_v, input logic el, input logic es,
                      input logic ec, input string nm, input int k);
    @(negedge dac_clk);
    reset      = rst_v;
    power_down = pd_v;
    @(posedge dac_clk);
    exp_q.push_back({el, es, ec});
    name_q.push_back(nm);
    seq_q.push_back(k);
  endtask

  // Edge k after leaving RESET/PWRDN: locked from edge 64, clock from edge 65
  task automatic lock_seq(input string nm, input int first, input int last);
    for (int k = first; k <= last; k++)
      step(1'b1, 1'b0, (k >= 64), 1'b0, (k >= 65), nm, k);
  endtask

  task automatic reset_hold(input string nm, input int n);
    for (int k = 1; k <= n; k++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, nm, k);
  endtask

  initial begin : stim
    int  e0;
    int  waited;
    time p;

    #100 reset = 1'b0;
    #1;
    check("por_locked", int'(locked), 0);
    check("por_stopped", int'(input_clk_stopped), 1);
    check("por_clk_out", int'(clk_out[1]), 0);

    reset_hold("reset_hold", 200);
    lock_seq("release", 1, 70);

    // Frequency: 257 consecutive rising edges give 256 periods
    rise_t.delete();
    waited = 0;
    while (rise_t.size() < 257 && waited < 400) begin
      @(posedge dac_clk);
      waited++;
    end
    #2;
    check("freq_edge_count", (rise_t.size() >= 257) ? 1 : 0, 1);
    if (rise_t.size() >= 257) begin
      for (int i = 1; i <= 256; i++) begin
        p = rise_t[i] - rise_t[i-1];
        checks++;
        if (p < 3025 || p > 3225) begin
          errors++;
          $display("FAIL freq_period[%0d]: got %0t ps required 3125+-100 ps", i, p);
        end
      end
    end

    // Power-down for 10 cycles while locked
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "pd_enter", 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "pd_hold", 1);
    e0 = clk_edges;
    for (int k = 2; k <= 9; k++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "pd_hold", k);
    lock_seq("pd_relock", 1, 1);
    check("pd_no_clk_edges", clk_edges - e0, 0);
    lock_seq("pd_relock", 2, 70);

    // power_down on the same edge the lock would complete
    reset_hold("prio_rst", 2);
    lock_seq("prio_pre", 1, 63);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "prio_collide", 64);
    lock_seq("prio_relock", 1, 70);

    // Async reset in the middle of a high phase
    @(posedge dac_clk);
    #781;
    reset = 1'b0;
    #1;
    check("async_still_high", int'(dac_clk), 1);
    check("async_locked", int'(locked), 0);
    check("async_stopped", int'(input_clk_stopped), 1);
    check("async_clk_out", int'(clk_out[1]), 0);
    reset_hold("async_hold", 5);
    lock_seq("async_relock", 1, 70);

    // pcie_clk toggling, held low, held high: identical behaviour expected
    for (int m = 0; m < 3; m++) begin
      pcie_mode = m;
      reset_hold($sformatf("pcie%0d_rst", m), 3);
      lock_seq($sformatf("pcie%0d_lock", m), 1, 70);
    end

    repeat (3) @(posedge dac_clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_wiz_example_design.md
# clk_wiz_example_design

Single-clock behavioural model of the clocking-wizard example design. It takes the DAC reference clock, runs a lock-acquisition sequence, and drives a glitch-free 1:1 gated copy of that clock on `CLK_OUT[1]` together with `locked` and `input_clk_stopped` status. It sits at the clocking boundary, between the board reference clocks and downstream logic that waits for `locked`.

## Interface
Parameters:
- `PER_DAC_CLK`, default 3125 (ps): nominal `dac_clk` period. Informational only, with no effect on RTL behaviour.
- `PER_PCIE_CLK`, default 3125 (ps): nominal `pcie_clk` period. Informational only.
- `LOCK_CYCLES`, default 64: number of `dac_clk` rising edges spent in LOCKING before `locked` asserts. Legal range 1..65535.

Ports:
- `dac_clk`  in  1: the single clock. All logic runs on it.
- `reset`  in  1: reset, asynchronous, active-low (0 = in reset).
- `power_down`  in  1: synchronous to `dac_clk`, active-high power-down request.
- `pcie_clk`  in  1: secondary reference pin, kept for pin compatibility. It is unused internally and has no effect on outputs.
- `CLK_OUT`  out  [1:1]: gated output clock, same frequency and phase as `dac_clk` when enabled.
- `locked`  out  1: output clock valid and stable.
- `input_clk_stopped`  out  1: output clock is held off because of reset or power-down.

## Operation
State machine on `dac_clk` rising edge, with 16-bit lock counter `lock_cnt`:
- RESET: entered asynchronously while `reset`=0. `locked`=0, `input_clk_stopped`=1, `lock_cnt`=0, clock enable=0.
- LOCKING: entered on the first rising edge with `reset`=1 and `power_down`=0.
  - `input_clk_stopped`=0, `locked`=0.
  - `lock_cnt` increments on every edge.
  - When `lock_cnt` reaches `LOCK_CYCLES`-1, go to LOCKED.
- LOCKED: `locked`=1, clock enable=1, `input_clk_stopped`=0. Stays in LOCKED until power-down or reset.
- PWRDN: entered from LOCKING or LOCKED on any rising edge where `power_down`=1.
  - `locked`=0, clock enable=0, `input_clk_stopped`=1, `lock_cnt` cleared.
  - Returns to LOCKING on the first edge with `power_down`=0, so the full lock sequence repeats.
- If `power_down`=1 while leaving RESET, go directly to PWRDN.
- Simultaneous events: reset has priority over everything. `power_down` has priority over lock completion, so no `locked` pulse is produced on the edge where both occur.

Clock gating:
- `gate_q` is a falling-edge register on `dac_clk` that samples the clock enable. It is asynchronously cleared by `reset`=0.
- `CLK_OUT[1]` = `dac_clk` AND `gate_q`.
- Because `gate_q` changes only while `dac_clk` is low, the output never produces a runt pulse.
- While disabled, `CLK_OUT[1]` is held at 0.

All registered outputs (`locked`, `input_clk_stopped`, state, `lock_cnt`, `gate_q`) take the RESET values above immediately when `reset` falls, with no clock required.

## Timing
- `locked` rises on the `LOCK_CYCLES`-th rising edge after the first edge with `reset`=1 (LOCKING entry edge counts as 1).
- `CLK_OUT[1]` first goes high on the rising edge after `locked` rises: `gate_q` sets on the intervening falling edge.
- Once enabled, `CLK_OUT[1]` period equals the `dac_clk` period (3125 ps nominal, 320 MHz). Duty cycle follows `dac_clk`, and delay is one AND gate.
- `power_down` asserted at edge N:
  - `locked`=0 and `input_clk_stopped`=1 after edge N.
  - `CLK_OUT[1]` last high phase is at edge N. It is low from the falling edge after N onward.
- `input_clk_stopped` falls on the LOCKING-entry edge.
- Mid-operation reset: `CLK_OUT[1]` forces to 0 asynchronously, even mid high phase. This is the one permitted truncated pulse.

## Test plan
- Reset then release: hold `reset`=0 for 200 cycles, check `locked`=0, `input_clk_stopped`=1, `CLK_OUT`=0. Release and check `input_clk_stopped` falls on edge 1, `locked` rises on edge 64, and `CLK_OUT[1]` first high at edge 65.
- Frequency: after lock, measure 256 consecutive `CLK_OUT[1]` rising edges with `dac_clk`=3125 ps. Every period must be 3125 ps ±100 ps (320 MHz).
- Power-down: in LOCKED, pulse `power_down`=1 for 10 cycles. Check `locked`=0, `input_clk_stopped`=1, and no `CLK_OUT` edges. After release, `locked` returns exactly 64 edges later.
- Async reset mid-operation: drop `reset` halfway through a `dac_clk` high phase while locked. Check all outputs clear immediately with no clock edge, and that relock takes 64 edges.
- Priority: assert `power_down` on the same edge that `lock_cnt` reaches `LOCK_CYCLES`-1. Check `locked` never pulses.
- `pcie_clk`: toggle it at 3125 ps, then hold it at 0 and at 1. Check outputs are identical in all three cases.
